// File: rtl/fifo_pkg.sv
// Shared FIFO types and pointer encoding helpers.
// Used by the write/read pointer controllers and the synchronizers.
package fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } wr_state_e;

    function automatic logic [31:0] bin2gray(
        input logic [31:0] b
    );
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(
        input logic [31:0] g
    );
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Producer-side write handshake of the FIFO write controller.
// The producer drives valid, the controller returns ready.
interface fifo_wr_ptr_ctrl_if;

    logic wr_valid;
    logic wr_ready;

    modport master (
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        output wr_ready
    );

endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller of an async FIFO: pointers,
// occupancy flags, flush/drain FSM and stall counter.
module fifo_wr_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fifo_wr_ptr_ctrl_if.slave     wr_if,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH:0]   rd_ptr_sync_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [ADDR_WIDTH:0]   wr_ptr_bin_o,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  flush_done_o,
    output logic                  ptr_err_o,
    output logic [15:0]           drop_cnt_o
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2 ** ADDR_WIDTH);
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

    wr_state_e     state_q;
    wr_state_e     state_d;
    logic          wr_fire;
    logic          wr_stall;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] lvl_next;

    assign wr_if.wr_ready = (state_q == RUN) && !full_o;
    assign wr_fire  = wr_if.wr_valid && wr_if.wr_ready;
    assign wr_stall = wr_if.wr_valid && !wr_if.wr_ready;

    assign mem_we_o   = wr_fire;
    assign mem_addr_o = wr_ptr_bin_o[ADDR_WIDTH-1:0];

    assign wr_ptr_next = wr_ptr_bin_o + PW'(wr_fire);
    // Modular difference; a stale read pointer only overstates level.
    assign lvl_next    = wr_ptr_next - rd_ptr_sync_i;

    always_comb begin
        state_d      = state_q;
        flush_done_o = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (level_o == '0 && !flush_i) begin
                    state_d      = RUN;
                    flush_done_o = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            wr_ptr_bin_o  <= '0;
            wr_ptr_gray_o <= '0;
            level_o       <= '0;
            full_o        <= 1'b0;
            almost_full_o <= 1'b0;
            ptr_err_o     <= 1'b0;
            drop_cnt_o    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_bin_o  <= wr_ptr_next;
            wr_ptr_gray_o <= PW'(bin2gray(32'(wr_ptr_next)));
            level_o       <= lvl_next;
            full_o        <= (lvl_next == DEPTH);
            almost_full_o <= (lvl_next >= AF_LVL);
            if (lvl_next > DEPTH) ptr_err_o <= 1'b1;
            if (wr_stall && drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Scoreboard bench for fifo_wr_ptr_ctrl (ADDR_WIDTH=4, AF_THRESH=12):
// stimulus pushes model expectations, a negedge monitor compares.
module tb_fifo_wr_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] rd_ptr = '0;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [4:0] wr_bin;
    logic [4:0] wr_gray;
    logic [4:0] level;
    logic       full;
    logic       afull;
    logic       fdone;
    logic       perr;
    logic [15:0] drop;

    int total = 0;
    int bad = 0;
    int epoch = 0;

    fifo_wr_ptr_ctrl_if wif ();

    fifo_wr_ptr_ctrl #(
        .ADDR_WIDTH(4),
        .AF_THRESH (12)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_if        (wif.slave),
        .flush_i      (flush),
        .rd_ptr_sync_i(rd_ptr),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .wr_ptr_bin_o (wr_bin),
        .wr_ptr_gray_o(wr_gray),
        .level_o      (level),
        .full_o       (full),
        .almost_full_o(afull),
        .flush_done_o (fdone),
        .ptr_err_o    (perr),
        .drop_cnt_o   (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ready;
        bit we;
        bit full;
        bit af;
        bit done;
        bit err;
        int addr;
        int bin;
        int gray;
        int level;
        int drop;
    } exp_t;

    exp_t q[$];

    // Reference model: pointer as a count mod 32, flags from occupancy.
    int m_wr;
    int m_level;
    int m_drop;
    bit m_drain;
    bit m_full;
    bit m_af;
    bit m_err;

    task automatic model_reset();
        m_wr = 0;
        m_level = 0;
        m_drop = 0;
        m_drain = 0;
        m_full = 0;
        m_af = 0;
        m_err = 0;
    endtask

    task automatic chk(
        input string nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input bit fl);
        exp_t e;
        bit   fire;
        int   lv;
        wif.wr_valid = v;
        flush = fl;
        e.ready = !m_drain && !m_full;
        fire    = v && e.ready;
        e.we    = fire;
        e.addr  = m_wr % 16;
        e.bin   = m_wr;
        e.gray  = m_wr ^ (m_wr >> 1);
        e.level = m_level;
        e.full  = m_full;
        e.af    = m_af;
        e.done  = m_drain && m_level == 0 && !fl;
        e.err   = m_err;
        e.drop  = m_drop;
        q.push_back(e);
        if (v && !e.ready && m_drop < 65535) m_drop++;
        m_wr    = (m_wr + int'(fire)) % 32;
        lv      = (m_wr - int'(rd_ptr) + 32) % 32;
        m_level = lv;
        m_full  = (lv == 16);
        m_af    = (lv >= 12);
        if (lv > 16) m_err = 1;
        if (!m_drain) m_drain = fl;
        else if (e.done) m_drain = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bin"},   32'(wr_bin),  0);
        chk({tag, "_gray"},  32'(wr_gray), 0);
        chk({tag, "_level"}, 32'(level),   0);
        chk({tag, "_full"},  32'(full),    0);
        chk({tag, "_af"},    32'(afull),   0);
        chk({tag, "_done"},  32'(fdone),   0);
        chk({tag, "_err"},   32'(perr),    0);
        chk({tag, "_drop"},  32'(drop),    0);
        chk({tag, "_ready"}, 32'(wif.wr_ready), 1);
        chk({tag, "_we"},    32'(mem_we),  0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        wif.wr_valid = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals(tag);
        model_reset();
        epoch++;
        rd_ptr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, checked at the falling edge.
    initial begin : monitor
        exp_t e;
        logic [4:0] prev_gray;
        bit have_prev;
        int seen_epoch;
        have_prev = 0;
        seen_epoch = 0;
        prev_gray = '0;
        forever begin
            @(negedge clk);
            if (seen_epoch != epoch) begin
                have_prev = 0;
                seen_epoch = epoch;
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ready", 32'(wif.wr_ready), 32'(e.ready));
                chk("we",    32'(mem_we),   32'(e.we));
                chk("addr",  32'(mem_addr), e.addr);
                chk("bin",   32'(wr_bin),   e.bin);
                chk("gray",  32'(wr_gray),  e.gray);
                chk("level", 32'(level),    e.level);
                chk("full",  32'(full),     32'(e.full));
                chk("afull", 32'(afull),    32'(e.af));
                chk("fdone", 32'(fdone),    32'(e.done));
                chk("perr",  32'(perr),     32'(e.err));
                chk("drop",  32'(drop),     e.drop);
                if (have_prev) begin
                    chk("gray_1bit",
                        32'($countones(prev_gray ^ wr_gray) <= 1), 1);
                end
                prev_gray = wr_gray;
                have_prev = 1;
            end
        end
    end

    initial begin : stim
        wif.wr_valid = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("por");
        repeat (3) step(0, 0);
        // fill to full, then stall
        repeat (16) step(1, 0);
        repeat (5) step(1, 0);
        rd_ptr = 5'd1;
        repeat (3) step(1, 0);
        rd_ptr = 5'(m_wr);
        repeat (2) step(0, 0);
        // streaming write/read through the pointer wrap
        for (int i = 0; i < 40; i++) begin
            rd_ptr = 5'(m_wr);
            step(1, 0);
        end
        rd_ptr = 5'(m_wr);
        step(0, 0);
        // flush pulse at level 3, reads drain it
        repeat (3) step(1, 0);
        step(0, 1);
        repeat (2) step(1, 0);
        for (int i = 0; i < 3; i++) begin
            rd_ptr = rd_ptr + 5'd1;
            step(1, 0);
        end
        repeat (3) step(1, 0);
        // flush held at level 0
        repeat (3) step(0, 1);
        repeat (3) step(0, 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit fl;
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 2) == 0 &&
                ((m_wr - int'(rd_ptr) + 32) % 32) != 0) begin
                rd_ptr = rd_ptr + 5'd1;
            end
            step(v, fl);
        end
        // reset while draining at level 5
        rd_ptr = 5'(m_wr);
        step(0, 0);
        repeat (5) step(1, 0);
        repeat (2) step(0, 1);
        async_reset("drain_rst");
        repeat (2) step(1, 0);
        // pointer inconsistency, sticky until reset
        rd_ptr = 5'd20;
        repeat (2) step(0, 0);
        rd_ptr = 5'd17;
        step(0, 0);
        rd_ptr = 5'd2;
        repeat (4) step(1, 0);
        async_reset("err_rst");
        step(0, 0);
        repeat (2) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
